// File: rtl/counter_sequencer_if.sv
// counter_sequencer_if
//   Groups the control inputs and status outputs of counter_sequencer.
//   master: board-level control side (drives start/stop/config, observes status).
//   slave : the sequencer itself.
//   Signals:
//     start, stop     start / abort requests
//     mode[1:0]       sequence select
//     lo, hi          lower / upper bound (WIDTH bits)
//     div             step period minus one (DIV_W bits)
//     count           current count value
//     dir             0 = up, 1 = down
//     busy            sequence in progress
//     tick, wrap      one-cycle pulses per step / per wrap or reversal
//     done, err       one-cycle pulses on one-shot completion / rejected start
interface counter_sequencer_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DIV_W = 8
);
    logic             start;
    logic             stop;
    logic [1:0]       mode;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic [DIV_W-1:0] div;
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             busy;
    logic             tick;
    logic             wrap;
    logic             done;
    logic             err;

    modport master (
        output start, stop, mode, lo, hi, div,
        input  count, dir, busy, tick, wrap, done, err
    );

    modport slave (
        input  start, stop, mode, lo, hi, div,
        output count, dir, busy, tick, wrap, done, err
    );
endinterface

// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Up/down counter sequencer with an internal prescaler. Runs one of four
//   count sequences between latched bounds LO and HI and reports progress
//   through busy/tick/wrap/done; err flags a start with LO > HI.
//   Ports:
//     clk_i  system clock, all state updates on posedge
//     rst_i  asynchronous reset, active-high
//     bus    counter_sequencer_if.slave (control inputs, status outputs)
module counter_sequencer #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DIV_W = 8
) (
    input logic                 clk_i,
    input logic                 rst_i,
    counter_sequencer_if.slave  bus
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    typedef enum logic [1:0] {
        M_UP_ONESHOT   = 2'b00,
        M_DOWN_ONESHOT = 2'b01,
        M_UP_WRAP      = 2'b10,
        M_PING_PONG    = 2'b11
    } mode_t;

    state_t           state_q, state_d;
    mode_t            mode_q, mode_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] inc;
    logic [WIDTH-1:0] dec;
    logic             oneshot;

    assign inc     = count_q + WIDTH'(1);
    assign dec     = count_q - WIDTH'(1);
    assign oneshot = (mode_q == M_UP_ONESHOT) || (mode_q == M_DOWN_ONESHOT);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            mode_q  <= M_UP_ONESHOT;
            lo_q    <= '0;
            hi_q    <= '0;
            div_q   <= '0;
            presc_q <= '0;
            count_q <= '0;
            dir_q   <= 1'b0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            div_q   <= div_d;
            presc_q <= presc_d;
            count_q <= count_d;
            dir_q   <= dir_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        div_d   = div_q;
        presc_d = presc_q;
        count_d = count_q;
        dir_d   = dir_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // stop overrides start: neither accepted nor reported as error
                if (bus.start && !bus.stop) begin
                    if (bus.lo <= bus.hi) begin
                        state_d = S_RUN;
                        mode_d  = mode_t'(bus.mode);
                        lo_d    = bus.lo;
                        hi_d    = bus.hi;
                        div_d   = bus.div;
                        presc_d = '0;
                        if (mode_t'(bus.mode) == M_DOWN_ONESHOT) begin
                            count_d = bus.hi;
                            dir_d   = 1'b1;
                        end else begin
                            count_d = bus.lo;
                            dir_d   = 1'b0;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_RUN: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                    presc_d = '0;
                end else if (oneshot && (lo_q == hi_q)) begin
                    // degenerate one-shot: already at the target, finish without a step
                    state_d = S_IDLE;
                    presc_d = '0;
                    done_d  = 1'b1;
                end else if (presc_q == div_q) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                    case (mode_q)
                        M_UP_ONESHOT: begin
                            count_d = inc;
                            if (inc == hi_q) begin
                                done_d  = 1'b1;
                                state_d = S_IDLE;
                            end
                        end
                        M_DOWN_ONESHOT: begin
                            count_d = dec;
                            if (dec == lo_q) begin
                                done_d  = 1'b1;
                                state_d = S_IDLE;
                            end
                        end
                        M_UP_WRAP: begin
                            if (count_q == hi_q) begin
                                count_d = lo_q;
                                wrap_d  = 1'b1;
                            end else begin
                                count_d = inc;
                            end
                        end
                        M_PING_PONG: begin
                            if (lo_q == hi_q) begin
                                wrap_d = 1'b1;
                            end else if (!dir_q) begin
                                count_d = inc;
                                if (inc == hi_q) begin
                                    dir_d  = 1'b1;
                                    wrap_d = 1'b1;
                                end
                            end else begin
                                count_d = dec;
                                if (dec == lo_q) begin
                                    dir_d  = 1'b0;
                                    wrap_d = 1'b1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    presc_d = presc_q + DIV_W'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign bus.count = count_q;
    assign bus.dir   = dir_q;
    assign bus.busy  = (state_q == S_RUN);
    assign bus.tick  = tick_q;
    assign bus.wrap  = wrap_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Sequencer for a WIDTH-bit up/down counter with an internal prescaler.
- Runs one of four programmed count sequences between a lower bound LO and an upper bound HI.
- Reports progress to the surrounding FPGA lab top level through BUSY, TICK, WRAP and DONE.
- Sits between the board-level control inputs (switches/buttons, already synchronised) and the LED/7-seg display of COUNT.

Parameters:
WIDTH, 4, counter width in bits.
DIV_W, 8, prescaler divisor width in bits.

Ports:
CLK    input   1        system clock, all state updates on posedge.
RST    input   1        asynchronous reset, active-high.
START  input   1        start request, sampled only in IDLE.
STOP   input   1        abort request.
MODE   input   2        sequence select, latched on accepted START.
LO     input   WIDTH    lower bound, latched on accepted START.
HI     input   WIDTH    upper bound, latched on accepted START.
DIV    input   DIV_W    step period minus one, latched on accepted START.
COUNT  output  WIDTH    current count value.
DIR    output  1        0 = counting up, 1 = counting down.
BUSY   output  1        sequence in progress.
TICK   output  1        one-cycle pulse on every count step.
WRAP   output  1        one-cycle pulse on wrap or direction reversal.
DONE   output  1        one-cycle pulse on one-shot completion.
ERR    output  1        one-cycle pulse on rejected START.

Behaviour:
- Reset (asynchronous, on RST high):
  - state = IDLE; COUNT = 0; DIR = 0; BUSY = 0; TICK = WRAP = DONE = ERR = 0.
  - Prescaler and latched config cleared.
- States: IDLE, RUN.
- In IDLE:
  - START=1 and STOP=0 and LO<=HI: latch MODE/LO/HI/DIV. Next edge: RUN, BUSY=1, prescaler=0.
    - COUNT = HI for MODE=01, otherwise COUNT = LO.
    - DIR = 1 for MODE=01, otherwise DIR = 0.
  - START=1 and LO>HI: stay IDLE, ERR=1 for one cycle, COUNT unchanged.
  - START and STOP both high: STOP wins, START ignored, no ERR.
- Prescaler (RUN only):
  - Counts 0..DIV. At DIV it returns to 0 and a step occurs.
  - The first step happens DIV+1 cycles after BUSY rises; DIV=0 steps every cycle.
  - TICK=1 in the cycle after each step edge (registered).
- Steps per MODE (all arithmetic modulo 2^WIDTH; the bounds guarantee no overflow):
  - 00 UP_ONESHOT: COUNT+1. The step that writes HI also sets DONE=1 (one cycle), BUSY=0, state IDLE. COUNT holds HI.
  - 01 DOWN_ONESHOT: COUNT-1. The step that writes LO also sets DONE=1, BUSY=0, state IDLE. COUNT holds LO, DIR stays 1.
  - 10 UP_WRAP: COUNT+1. At HI, the next step loads LO and pulses WRAP. Runs until STOP.
  - 11 PING_PONG:
    - DIR=0: COUNT+1. The step writing HI also sets DIR=1 and pulses WRAP.
    - DIR=1: COUNT-1. The step writing LO also sets DIR=0 and pulses WRAP.
    - Runs until STOP.
- LO==HI:
  - Modes 00/01: no steps. DONE pulses and BUSY drops on the edge after BUSY rose (two edges after START).
  - Modes 10/11: COUNT stays constant; TICK and WRAP pulse on every step. DIR stays 0.
- STOP in RUN:
  - Next edge: IDLE, BUSY=0, COUNT and DIR hold, prescaler cleared.
  - No DONE. If a step coincides with STOP, STOP wins and the step is not applied.
- START while in RUN: ignored.
- LO/HI/MODE/DIV changes during RUN: no effect until the next accepted START.
- Mid-run reset: immediately forces reset values; no DONE pulse.
- Every pulse output is high for exactly one cycle per event. DONE and TICK coincide on the completing step.

Test Plan:
- Reset mid-RUN at COUNT=7 -> all outputs 0 immediately (asynchronous, before the next CLK edge); START afterwards accepted normally.
- MODE=00, LO=2, HI=5, DIV=0:
  - COUNT 2,3,4,5 on consecutive cycles after BUSY rises.
  - DONE=1 with COUNT=5; BUSY falls on the same edge; TICK pulses 3 times.
- MODE=11, LO=1, HI=3, DIV=2:
  - COUNT 1,2,3,2,1,2…, changing every 3 cycles.
  - WRAP at 3 (DIR->1) and at 1 (DIR->0).
  - STOP while COUNT=2 -> BUSY=0, COUNT=2 held, no DONE.
- MODE=10, LO=14, HI=15, DIV=0 -> COUNT 14,15,14,15; WRAP on each 15->14 step; no DONE.
- LO=9, HI=4, START -> ERR one cycle, BUSY stays 0. Then START with STOP=1 and LO<=HI -> ignored, no ERR.
- MODE=01, LO=HI=6 -> COUNT=6, DIR=1, DONE pulse on the edge after BUSY rose, zero TICKs.
